// File: rtl/rock_ctrl.sv
// rock_ctrl: averages heart-rate/cry-volume samples and ramps cradle rocking amplitude/frequency.
// Optional build macro ROCK_WATCHDOG_EN adds a sensor-silence watchdog (fault output).
`default_nettype none

module rock_ctrl #(
  parameter int SENS_W     = 8,
  parameter int OUT_W      = 3,
  parameter int AVG_LOG2   = 2,
  parameter int HR_HI      = 140,
  parameter int CRY_HI     = 100,
  parameter int STEP_TICKS = 4,
  parameter int CALM_TICKS = 8,
  parameter int WD_TICKS   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              sample_valid,
  input  logic [SENS_W-1:0] hartslag,
  input  logic [SENS_W-1:0] huil_vol,
  output logic [OUT_W-1:0]  amp,
  output logic [OUT_W-1:0]  freq,
  output logic [1:0]        state,
  output logic              fault
);

  localparam int ACC_W  = SENS_W + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int CALM_W = $clog2(CALM_TICKS + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
  localparam logic [CALM_W-1:0] CALM_END  = CALM_W'(CALM_TICKS);
  localparam logic [SENS_W-1:0] HR_TH     = SENS_W'(HR_HI);
  localparam logic [SENS_W-1:0] CRY_TH    = SENS_W'(CRY_HI);
  localparam logic [OUT_W-1:0]  CODE_MAX  = {OUT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t             cur_state, nxt_state;
  logic [ACC_W-1:0]   acc_hr, acc_cry;
  logic [ACC_W-1:0]   hr_sum, cry_sum;
  logic [CNT_W-1:0]   smp_cnt;
  logic [SENS_W-1:0]  hr_avg, cry_avg;
  logic [STEP_W-1:0]  step_cnt, step_nxt;
  logic [CALM_W-1:0]  calm_cnt, calm_nxt;
  logic [OUT_W-1:0]   amp_nxt, freq_nxt;
  logic [OUT_W-1:0]   amp_dn, freq_dn;
  logic               stress;
  logic               wd_hit;

  assign hr_sum  = acc_hr + ACC_W'(hartslag);
  assign cry_sum = acc_cry + ACC_W'(huil_vol);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_hr  <= '0;
      acc_cry <= '0;
      smp_cnt <= '0;
      hr_avg  <= '0;
      cry_avg <= '0;
    end else if (wd_hit) begin
      acc_hr  <= '0;
      acc_cry <= '0;
      smp_cnt <= '0;
      hr_avg  <= '0;
      cry_avg <= '0;
    end else if (sample_valid) begin
      if (smp_cnt == CNT_LAST) begin
        // Window complete: the current sample is folded into this average.
        hr_avg  <= hr_sum[ACC_W-1:AVG_LOG2];
        cry_avg <= cry_sum[ACC_W-1:AVG_LOG2];
        acc_hr  <= '0;
        acc_cry <= '0;
        smp_cnt <= '0;
      end else begin
        acc_hr  <= hr_sum;
        acc_cry <= cry_sum;
        smp_cnt <= smp_cnt + 1'b1;
      end
    end
  end

  // Registered averages only, so a same-cycle sample never affects this tick.
  assign stress = ((hr_avg > HR_TH) || (cry_avg > CRY_TH)) && !wd_hit && !fault;

`ifdef ROCK_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_TICKS + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_TICKS - 1);
  localparam logic [WD_W-1:0] WD_END  = WD_W'(WD_TICKS);

  logic [WD_W-1:0] wd_cnt;

  assign wd_hit = tick && !sample_valid && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      fault  <= 1'b0;
    end else if (sample_valid) begin
      wd_cnt <= '0;
      fault  <= 1'b0;
    end else if (tick && (wd_cnt != WD_END)) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_hit) fault <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign fault  = 1'b0;
`endif

  assign amp_dn  = (amp == '0) ? amp : amp - 1'b1;
  assign freq_dn = (freq == '0) ? freq : freq - 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
      amp       <= '0;
      freq      <= '0;
      step_cnt  <= '0;
      calm_cnt  <= '0;
    end else begin
      cur_state <= nxt_state;
      amp       <= amp_nxt;
      freq      <= freq_nxt;
      step_cnt  <= step_nxt;
      calm_cnt  <= calm_nxt;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    amp_nxt   = amp;
    freq_nxt  = freq;
    step_nxt  = step_cnt;
    calm_nxt  = calm_cnt;
    if (tick) begin
      case (cur_state)
        IDLE: begin
          if (stress) begin
            nxt_state = RAMP_UP;
            step_nxt  = '0;
          end
        end
        RAMP_UP: begin
          if (wd_hit) begin
            nxt_state = RAMP_DOWN;
            step_nxt  = '0;
          end else if (stress) begin
            if (step_cnt == STEP_LAST) begin
              step_nxt = '0;
              amp_nxt  = (amp == CODE_MAX) ? amp : amp + 1'b1;
              freq_nxt = (freq == CODE_MAX) ? freq : freq + 1'b1;
            end else begin
              step_nxt = step_cnt + 1'b1;
            end
          end else begin
            nxt_state = HOLD;
            calm_nxt  = '0;
          end
        end
        HOLD: begin
          if (wd_hit) begin
            nxt_state = RAMP_DOWN;
            step_nxt  = '0;
          end else if (stress) begin
            nxt_state = RAMP_UP;
            step_nxt  = '0;
          end else begin
            calm_nxt = calm_cnt + 1'b1;
            if (calm_cnt + 1'b1 == CALM_END) begin
              nxt_state = RAMP_DOWN;
              step_nxt  = '0;
            end
          end
        end
        default: begin
          if (stress) begin
            nxt_state = RAMP_UP;
            step_nxt  = '0;
          end else if (step_cnt == STEP_LAST) begin
            step_nxt = '0;
            amp_nxt  = amp_dn;
            freq_nxt = freq_dn;
            if ((amp_dn == '0) && (freq_dn == '0)) nxt_state = IDLE;
          end else begin
            step_nxt = step_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign state = cur_state;

endmodule

`default_nettype wire
